// File: rtl/tdm_demux4_pkg.sv
// Shared constants and state type for the 4-slot TDM receiver.
//   NSLOT   : slots per frame
//   SLOT_W  : width of the slot index
//   state_t : framing FSM state (HUNT = searching for sync, LOCKED = aligned)
package tdm_pkg;

  localparam int unsigned NSLOT  = 4;
  localparam int unsigned SLOT_W = 2;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_demux4_if.sv
// Serial link into the TDM receiver.
//   din        : slot word
//   din_valid  : din carries a slot this cycle
//   frame_sync : marks din as slot 0 (only meaningful with din_valid)
// master = link driver, slave = receiver.
interface tdm_demux4_if #(
  parameter int unsigned W = 1
);
  logic [W-1:0] din;
  logic         din_valid;
  logic         frame_sync;

  modport master (output din, din_valid, frame_sync);
  modport slave  (input  din, din_valid, frame_sync);
endinterface

// File: rtl/tdm_demux4_slot_ctr.sv
// Framing FSM and slot counter for the TDM receiver.
//   clk, rst_n : clock, async active-low reset
//   accept     : a slot word is taken this cycle
//   frame_sync : current word is marked as slot 0
//   slot       : index the next accepted word will occupy (registered)
//   locked     : FSM is in LOCKED (registered)
//   capture_en : current word is to be stored (comb)
//   complete   : current word finishes a frame (comb)
//   sync_err   : one-cycle framing violation pulse (registered)
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              accept,
  input  logic              frame_sync,
  output logic [SLOT_W-1:0] slot,
  output logic              locked,
  output logic              capture_en,
  output logic              complete,
  output logic              sync_err
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SLOT_W-1:0] r_slot;
  logic [SLOT_W-1:0] w_slot_nxt;
  logic              r_sync_err;
  logic              w_sync_err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_HUNT;
      r_slot     <= '0;
      r_sync_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_slot     <= w_slot_nxt;
      r_sync_err <= w_sync_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_slot_nxt     = r_slot;
    w_sync_err_nxt = 1'b0;
    if (accept) begin
      case (r_state)
        ST_HUNT: begin
          if (frame_sync) begin
            w_state_nxt = ST_LOCKED;
            w_slot_nxt  = SLOT_W'(1);
          end
        end
        ST_LOCKED: begin
          if (frame_sync) begin
            // sync mid-frame re-aligns; sync at slot 0 is the normal case
            w_sync_err_nxt = (r_slot != '0);
            w_slot_nxt     = SLOT_W'(1);
          end else if (r_slot == '0) begin
            w_sync_err_nxt = 1'b1;
            w_state_nxt    = ST_HUNT;
            w_slot_nxt     = '0;
          end else begin
            w_slot_nxt = r_slot + SLOT_W'(1);
          end
        end
        default: w_state_nxt = ST_HUNT;
      endcase
    end
  end

  always_comb begin
    capture_en = 1'b0;
    complete   = 1'b0;
    if (accept) begin
      if (r_state == ST_HUNT) begin
        capture_en = frame_sync;
      end else begin
        capture_en = frame_sync || (r_slot != '0);
        complete   = !frame_sync && (r_slot == SLOT_W'(NSLOT - 1));
      end
    end
  end

  assign slot     = r_slot;
  assign locked   = (r_state == ST_LOCKED);
  assign sync_err = r_sync_err;

endmodule

// File: rtl/tdm_demux4.sv
// Receive end of a 4-slot TDM link: aligns serial slot words to frame_sync
// and presents each complete frame as four registered channel words.
//   clk, rst_n  : clock, async active-low reset
//   bus         : serial link (din, din_valid, frame_sync), slave side
//   z0..z3      : channel words of the last complete frame
//   frame_valid : one-cycle pulse when z0..z3 update
//   slot        : index of the next accepted word
//   locked      : receiver aligned to the frame
//   sync_err    : one-cycle framing violation pulse
//   frame_cnt   : completed frames, wraps modulo 2**CNT_W
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int unsigned W     = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  tdm_demux4_if.slave       bus,
  output logic [W-1:0]      z0,
  output logic [W-1:0]      z1,
  output logic [W-1:0]      z2,
  output logic [W-1:0]      z3,
  output logic              frame_valid,
  output logic [SLOT_W-1:0] slot,
  output logic              locked,
  output logic              sync_err,
  output logic [CNT_W-1:0]  frame_cnt
);

  logic              w_capture_en;
  logic              w_complete;
  logic [SLOT_W-1:0] w_idx;
  logic [W-1:0]      r_shadow [NSLOT-1];
  logic [W-1:0]      r_z      [NSLOT];
  logic              r_frame_valid;
  logic [CNT_W-1:0]  r_frame_cnt;

  tdm_slot_ctr u_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .accept     (bus.din_valid),
    .frame_sync (bus.frame_sync),
    .slot       (slot),
    .locked     (locked),
    .capture_en (w_capture_en),
    .complete   (w_complete),
    .sync_err   (sync_err)
  );

  // A synced word always lands in slot 0, including re-alignment.
  assign w_idx = bus.frame_sync ? '0 : slot;

  // Slot 3 is never shadowed: it goes straight to z3 on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NSLOT - 1; k++) r_shadow[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NSLOT - 1; k++) begin
        if (w_capture_en && (w_idx == SLOT_W'(k))) r_shadow[k] <= bus.din;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NSLOT; k++) r_z[k] <= '0;
      r_frame_valid <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_frame_valid <= w_complete;
      if (w_complete) begin
        for (int unsigned k = 0; k < NSLOT - 1; k++) r_z[k] <= r_shadow[k];
        r_z[NSLOT-1] <= bus.din;
        r_frame_cnt  <= r_frame_cnt + CNT_W'(1);
      end
    end
  end

  assign z0          = r_z[0];
  assign z1          = r_z[1];
  assign z2          = r_z[2];
  assign z3          = r_z[3];
  assign frame_valid = r_frame_valid;
  assign frame_cnt   = r_frame_cnt;

endmodule
